// File: rtl/pc_seq_pkg.sv
// Shared types and helpers for the fetch-stage PC sequencer.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2,
        STEP   = 2'd3
    } pc_seq_state_e;

    localparam logic [31:0] PC_INC = 32'd4;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/pc_sequencer.sv
// Fetch-stage controller: computes pc_next/pc_stall, arbitrates redirects, stalls,
// halt/debug requests and misaligned-target traps, and holds fetch for a boot window.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int unsigned BOOT_CYCLES  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_current,
    input  logic        hazard_stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        halt_req,
    input  logic        dbg_halt,
    input  logic        dbg_resume,
    input  logic        dbg_step,
    output logic [31:0] pc_next,
    output logic        pc_stall,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        halted,
    output logic        misalign_err,
    output logic [31:0] err_addr
);

    localparam int unsigned          CntW     = $clog2(BOOT_CYCLES + 1);
    localparam logic [CntW-1:0]      BootLast = CntW'(BOOT_CYCLES - 1);

    pc_seq_state_e   state_q, state_d;
    logic [CntW-1:0] boot_cnt_q, boot_cnt_d;
    logic            halted_q;
    logic            misalign_q, misalign_d;
    logic [31:0]     err_addr_q, err_addr_d;

    always_comb begin
        state_d     = state_q;
        boot_cnt_d  = boot_cnt_q;
        misalign_d  = misalign_q;
        err_addr_d  = err_addr_q;
        pc_next     = RESET_VECTOR;
        pc_stall    = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;

        case (state_q)
            BOOT: begin
                boot_cnt_d = boot_cnt_q + CntW'(1);
                if (boot_cnt_q == BootLast) begin
                    state_d = RUN;
                end
            end

            RUN, STEP: begin
                pc_next = pc_current;
                if (redirect_valid) begin
                    pc_stall    = 1'b0;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    if (is_misaligned(redirect_target)) begin
                        pc_next    = TRAP_VECTOR;
                        misalign_d = 1'b1;
                        // Only the first offending target is kept.
                        if (!misalign_q) begin
                            err_addr_d = redirect_target;
                        end
                    end else begin
                        pc_next = redirect_target;
                    end
                end else if (state_q == RUN && (halt_req || dbg_halt)) begin
                    if_id_flush = 1'b1;
                    state_d     = HALTED;
                end else if (hazard_stall) begin
                    id_ex_flush = 1'b1;
                end else begin
                    pc_next  = pc_current + PC_INC;
                    pc_stall = 1'b0;
                end

                // A single step ends once the PC has actually advanced.
                if (state_q == STEP && !pc_stall) begin
                    state_d = HALTED;
                end
            end

            HALTED: begin
                pc_next = pc_current;
                if (dbg_step) begin
                    state_d = STEP;
                end else if (dbg_resume) begin
                    state_d = RUN;
                end
            end

            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= BOOT;
            boot_cnt_q <= '0;
            halted_q   <= 1'b0;
            misalign_q <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
            halted_q   <= (state_d == HALTED);
            misalign_q <= misalign_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign halted       = halted_q;
    assign misalign_err = misalign_q;
    assign err_addr     = err_addr_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed and randomized checks of pc_sequencer against a mode-level reference model.
module tb_pc_sequencer;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] TV = 32'h0000_0100;
    localparam int          BC = 4;

    localparam int M_BOOT = 0, M_RUN = 1, M_HALT = 2, M_STEP = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_current;
    logic        hazard_stall = 0, redirect_valid = 0, halt_req = 0, dbg_halt = 0;
    logic        dbg_resume = 0, dbg_step = 0;
    logic [31:0] redirect_target = 0;
    logic [31:0] pc_next, err_addr;
    logic        pc_stall, if_id_flush, id_ex_flush, halted, misalign_err;

    logic        use_ext = 1'b0;
    logic [31:0] ext_pc = 32'h0;
    logic [31:0] pc_reg;

    int total = 0;
    int bad   = 0;

    int          mode;
    int          boot_left;
    logic        m_err;
    logic [31:0] m_eaddr;
    logic        m_halted;
    logic [31:0] e_next;
    logic        e_stall, e_ifid, e_idex, e_chk_next;

    always #5 clk = ~clk;

    assign pc_current = use_ext ? ext_pc : pc_reg;

    // Environment PC register fed by the sequencer.
    always @(posedge clk or posedge rst) begin
        if (rst)            pc_reg <= RV;
        else if (!pc_stall) pc_reg <= pc_next;
    end

    pc_sequencer #(
        .RESET_VECTOR (RV),
        .TRAP_VECTOR  (TV),
        .BOOT_CYCLES  (BC)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .pc_current      (pc_current),
        .hazard_stall    (hazard_stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .halt_req        (halt_req),
        .dbg_halt        (dbg_halt),
        .dbg_resume      (dbg_resume),
        .dbg_step        (dbg_step),
        .pc_next         (pc_next),
        .pc_stall        (pc_stall),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .halted          (halted),
        .misalign_err    (misalign_err),
        .err_addr        (err_addr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        mode      = M_BOOT;
        boot_left = BC;
        m_err     = 1'b0;
        m_eaddr   = 32'h0;
        m_halted  = 1'b0;
    endfunction

    function automatic void model_outputs();
        e_next     = RV;
        e_stall    = 1'b1;
        e_ifid     = 1'b0;
        e_idex     = 1'b0;
        e_chk_next = 1'b1;
        if (mode == M_HALT) begin
            e_chk_next = 1'b0;
        end else if (mode == M_RUN || mode == M_STEP) begin
            if (redirect_valid) begin
                e_stall = 1'b0;
                e_ifid  = 1'b1;
                e_idex  = 1'b1;
                e_next  = (redirect_target % 4 != 0) ? TV : redirect_target;
            end else if (mode == M_RUN && (halt_req || dbg_halt)) begin
                e_ifid     = 1'b1;
                e_chk_next = 1'b0;
            end else if (hazard_stall) begin
                e_idex     = 1'b1;
                e_chk_next = 1'b0;
            end else begin
                e_next  = pc_current + 32'd4;
                e_stall = 1'b0;
            end
        end
    endfunction

    function automatic void model_advance();
        case (mode)
            M_BOOT: begin
                boot_left--;
                if (boot_left == 0) mode = M_RUN;
            end
            M_HALT: begin
                if (dbg_step)        mode = M_STEP;
                else if (dbg_resume) mode = M_RUN;
            end
            default: begin
                if (redirect_valid && redirect_target % 4 != 0) begin
                    if (!m_err) m_eaddr = redirect_target;
                    m_err = 1'b1;
                end
                if (mode == M_RUN && !redirect_valid && (halt_req || dbg_halt)) mode = M_HALT;
                if (mode == M_STEP && !e_stall) mode = M_HALT;
            end
        endcase
        m_halted = (mode == M_HALT);
    endfunction

    task automatic check_now(input string tag);
        #1;
        model_outputs();
        chk({tag, ".stall"}, {31'b0, pc_stall}, {31'b0, e_stall});
        chk({tag, ".ifid"}, {31'b0, if_id_flush}, {31'b0, e_ifid});
        chk({tag, ".idex"}, {31'b0, id_ex_flush}, {31'b0, e_idex});
        chk({tag, ".halted"}, {31'b0, halted}, {31'b0, m_halted});
        chk({tag, ".merr"}, {31'b0, misalign_err}, {31'b0, m_err});
        chk({tag, ".eaddr"}, err_addr, m_eaddr);
        if (e_chk_next) chk({tag, ".next"}, pc_next, e_next);
    endtask

    task automatic adv();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic idle();
        hazard_stall = 0; redirect_valid = 0; redirect_target = 0;
        halt_req = 0; dbg_halt = 0; dbg_resume = 0; dbg_step = 0;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] tgt;
        // Reset and boot window
        rst = 1'b1;
        model_reset();
        check_now("in_reset");
        release_reset();
        for (int i = 0; i < BC; i++) begin
            check_now("boot");
            chk("boot_pc_next", pc_next, 32'h0);
            adv();
        end
        check_now("first_adv");
        chk("first_adv_next", pc_next, 32'h4);
        adv();
        chk("pc_after_boot", pc_reg, 32'h4);

        // Sequential increment and wrap
        use_ext = 1'b1;
        ext_pc = 32'h10;
        check_now("seq10");
        chk("seq10_next", pc_next, 32'h14);
        adv();
        ext_pc = 32'hFFFF_FFFC;
        check_now("wrap");
        chk("wrap_next", pc_next, 32'h0);
        adv();

        // Redirect beats a simultaneous hazard
        redirect_valid = 1; redirect_target = 32'h80; hazard_stall = 1;
        check_now("redir_haz");
        chk("redir_haz_next", pc_next, 32'h80);
        chk("redir_haz_stall", {31'b0, pc_stall}, 32'h0);
        adv();
        hazard_stall = 0;

        // Misaligned redirects trap; first address is sticky
        redirect_target = 32'h82;
        check_now("mis1");
        chk("mis1_next", pc_next, TV);
        adv();
        chk("mis1_err", {31'b0, misalign_err}, 32'h1);
        chk("mis1_addr", err_addr, 32'h82);
        redirect_target = 32'h86;
        check_now("mis2");
        adv();
        chk("mis2_addr", err_addr, 32'h82);

        // Hazard holds the PC
        use_ext = 1'b0;
        redirect_target = 32'h20;
        check_now("to20");
        adv();
        chk("pc_at20", pc_reg, 32'h20);
        idle();
        hazard_stall = 1;
        check_now("hazard");
        chk("hazard_idex", {31'b0, id_ex_flush}, 32'h1);
        chk("hazard_ifid", {31'b0, if_id_flush}, 32'h0);
        adv();
        chk("hazard_hold", pc_reg, 32'h20);

        // Halt, single step, resume
        hazard_stall = 0; halt_req = 1;
        check_now("halt");
        adv();
        halt_req = 0;
        chk("halted_set", {31'b0, halted}, 32'h1);
        check_now("halted_idle");
        adv();
        chk("halt_frozen", pc_reg, 32'h20);
        dbg_step = 1;
        check_now("step_req");
        adv();
        dbg_step = 0;
        check_now("stepping");
        chk("step_next", pc_next, 32'h24);
        adv();
        chk("step_pc", pc_reg, 32'h24);
        chk("step_rehalt", {31'b0, halted}, 32'h1);
        check_now("after_step");
        adv();
        chk("after_step_pc", pc_reg, 32'h24);
        dbg_resume = 1;
        check_now("resume");
        adv();
        dbg_resume = 0;
        check_now("run1");
        adv();
        check_now("run2");
        adv();
        chk("resume_pc", pc_reg, 32'h2C);

        // Reset asserted while stepping under a hazard
        halt_req = 1;
        check_now("halt2");
        adv();
        halt_req = 0; dbg_step = 1;
        check_now("step2_req");
        adv();
        dbg_step = 0; hazard_stall = 1;
        check_now("step2_stall");
        adv();
        check_now("step2_still");
        #1;
        rst = 1'b1;
        model_reset();
        check_now("rst_in_step");
        chk("rst_step_next", pc_next, RV);
        idle();
        release_reset();

        // Randomized run against the model
        for (int i = 0; i < 400; i++) begin
            hazard_stall   = ($urandom_range(0, 3) == 0);
            redirect_valid = ($urandom_range(0, 4) == 0);
            tgt = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) tgt = tgt | 32'($urandom_range(1, 3));
            redirect_target = tgt;
            halt_req   = ($urandom_range(0, 19) == 0);
            dbg_halt   = ($urandom_range(0, 19) == 0);
            dbg_resume = ($urandom_range(0, 2) == 0);
            dbg_step   = ($urandom_range(0, 4) == 0);
            check_now("rnd");
            adv();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
